adv_event_scheduler: RTL and testbench

//  Sequences one BLE advertising event: walks enabled advertising channels 37/38/39 in order,

---
 rtl/adv_event_scheduler_pkg.sv | 34 +++
 rtl/ble_sched_timer.sv | 30 +++
 rtl/adv_event_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_adv_event_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adv_event_scheduler_pkg.sv
// Shared state encoding, advertising channel numbers and mask helpers for the
// BLE advertising event scheduler.
package adv_event_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_TUNE     = 3'd2,
    ST_TX       = 3'd3,
    ST_GAP      = 3'd4,
    ST_INTERVAL = 3'd5
  } sched_state_e;

  localparam logic [5:0] CH_37 = 6'd37;
  localparam logic [5:0] CH_38 = 6'd38;
  localparam logic [5:0] CH_39 = 6'd39;

  localparam int DEFAULT_IFS = 150;

  // Isolates the lowest set bit of a channel mask (bit0 = ch37), giving the
  // next channel to visit in ascending order.
  function automatic logic [2:0] lowest_chan(input logic [2:0] mask);
    return mask & (~mask + 3'd1);
  endfunction

  function automatic logic [5:0] chan_index(input logic [2:0] onehot);
    logic [5:0] idx;
    if (onehot[0])      idx = CH_37;
    else if (onehot[1]) idx = CH_38;
    else                idx = CH_39;
    return idx;
  endfunction

endpackage

// File: rtl/ble_sched_timer.sv
// Loadable saturating down-counter with a zero flag; used for the event
// interval and for the shared inter-frame-gap / transmit-timeout count.
module ble_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         ready,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!ready) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/adv_event_scheduler.sv
// Sequences one BLE advertising event over channels 37/38/39, handing each
// channel to the synthesizer and then to the packet reader, and repeats events.
module adv_event_scheduler
  import adv_event_scheduler_pkg::*;
#(
  parameter int IFS_CYCLES = DEFAULT_IFS,
  parameter int TX_TIMEOUT = 65535,
  parameter int INTERVAL_W = 24,
  parameter int EVCNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  ready,
  input  logic                  enable,
  input  logic [INTERVAL_W-1:0] adv_interval,
  input  logic [2:0]            chan_map,
  input  logic                  chan_ack,
  input  logic                  pr_done,
  output logic                  chan_req,
  output logic [5:0]            channel,
  output logic                  pr_run,
  output logic                  busy,
  output logic [EVCNT_W-1:0]    event_cnt,
  output logic                  timeout_err
);

  localparam int TMR_MAX  = (TX_TIMEOUT > IFS_CYCLES) ? TX_TIMEOUT : IFS_CYCLES;
  localparam int TMR_W    = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
  // The gap count also covers the SELECT cycle, so chan_req rises exactly
  // IFS_CYCLES cycles after pr_run falls.
  localparam int GAP_LOAD = (IFS_CYCLES >= 2) ? IFS_CYCLES - 2 : 0;
  localparam int TO_LOAD  = (TX_TIMEOUT >= 1) ? TX_TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0] GAP_LOAD_V = TMR_W'(GAP_LOAD);
  localparam logic [TMR_W-1:0] TO_LOAD_V  = TMR_W'(TO_LOAD);
  localparam bit               TIMEOUT_EN = (TX_TIMEOUT != 0);

  sched_state_e state_q, state_d;

  logic [2:0]         map_q, map_d;
  logic [2:0]         visited_q, visited_d;
  logic               sent_q, sent_d;
  logic               chan_req_d;
  logic [5:0]         channel_d;
  logic               pr_run_d;
  logic [EVCNT_W-1:0] event_cnt_d;
  logic               timeout_err_d;

  logic [2:0]            pending;
  logic [2:0]            next_chan;
  logic                  start_event;
  logic                  ivl_load, ivl_dec, ivl_zero;
  logic [INTERVAL_W-1:0] ivl_load_val;
  logic                  tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]      tmr_load_val;

  // Interval loads N-1 so the next event starts N cycles after this one.
  assign ivl_load_val = (adv_interval == '0) ? '0 : adv_interval - INTERVAL_W'(1);
  assign ivl_dec      = (state_q != ST_IDLE);
  assign ivl_load     = start_event;

  ble_sched_timer #(.W(INTERVAL_W)) u_interval (
    .clk      (clk),
    .ready    (ready),
    .load     (ivl_load),
    .load_val (ivl_load_val),
    .dec      (ivl_dec),
    .zero     (ivl_zero)
  );

  ble_sched_timer #(.W(TMR_W)) u_gap_timeout (
    .clk      (clk),
    .ready    (ready),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!ready) begin
      state_q     <= ST_IDLE;
      map_q       <= '0;
      visited_q   <= '0;
      sent_q      <= 1'b0;
      chan_req    <= 1'b0;
      channel     <= CH_37;
      pr_run      <= 1'b0;
      busy        <= 1'b0;
      event_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      visited_q   <= visited_d;
      sent_q      <= sent_d;
      chan_req    <= chan_req_d;
      channel     <= channel_d;
      pr_run      <= pr_run_d;
      busy        <= (state_d != ST_IDLE);
      event_cnt   <= event_cnt_d;
      timeout_err <= timeout_err_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    map_d         = map_q;
    visited_d     = visited_q;
    sent_d        = sent_q;
    chan_req_d    = chan_req;
    channel_d     = channel;
    pr_run_d      = pr_run;
    event_cnt_d   = event_cnt;
    timeout_err_d = 1'b0;
    start_event   = 1'b0;
    tmr_load      = 1'b0;
    tmr_load_val  = '0;
    tmr_dec       = 1'b0;
    pending       = map_q & ~visited_q;
    next_chan     = lowest_chan(pending);

    unique case (state_q)
      ST_IDLE: begin
        if (enable) start_event = 1'b1;
      end

      ST_SELECT: begin
        if (!enable) begin
          chan_req_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (pending != '0) begin
          channel_d  = chan_index(next_chan);
          visited_d  = visited_q | next_chan;
          chan_req_d = 1'b1;
          state_d    = ST_TUNE;
        end else begin
          if (sent_q) event_cnt_d = event_cnt + EVCNT_W'(1);
          state_d = ST_INTERVAL;
        end
      end

      ST_TUNE: begin
        if (!enable) begin
          chan_req_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (chan_ack) begin
          chan_req_d   = 1'b0;
          pr_run_d     = 1'b1;
          sent_d       = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = TO_LOAD_V;
          state_d      = ST_TX;
        end
      end

      ST_TX: begin
        tmr_dec = 1'b1;
        // pr_done is checked first so a same-cycle timeout is not reported.
        if (pr_done || (TIMEOUT_EN && tmr_zero)) begin
          timeout_err_d = !pr_done;
          pr_run_d      = 1'b0;
          tmr_load      = 1'b1;
          tmr_load_val  = GAP_LOAD_V;
          state_d       = ST_GAP;
        end
      end

      ST_GAP: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = enable ? ST_SELECT : ST_IDLE;
      end

      ST_INTERVAL: begin
        if (ivl_zero) begin
          if (enable) start_event = 1'b1;
          else        state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Channel map is captured only here; later changes wait for the next event.
    if (start_event) begin
      map_d     = chan_map;
      visited_d = '0;
      sent_d    = 1'b0;
      state_d   = ST_SELECT;
    end
  end

endmodule

// File: tb/tb_adv_event_scheduler.sv
// Self-checking bench for adv_event_scheduler: directed and randomized events
// checked against a timeline model built from channel order and delay rules.
module tb_adv_event_scheduler;

  localparam int IFS  = 150;
  localparam int TXTO = 50;
  localparam int IVL  = 2000;

  logic        clk = 1'b0;
  logic        ready = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] adv_interval = '0;
  logic [2:0]  chan_map = '0;
  logic        chan_ack = 1'b0;
  logic        pr_done = 1'b0;
  logic        chan_req;
  logic [5:0]  channel;
  logic        pr_run;
  logic        busy;
  logic [15:0] event_cnt;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ev_model = 0;

  adv_event_scheduler #(
    .IFS_CYCLES (IFS),
    .TX_TIMEOUT (TXTO),
    .INTERVAL_W (24),
    .EVCNT_W    (16)
  ) dut (
    .clk          (clk),
    .ready        (ready),
    .enable       (enable),
    .adv_interval (adv_interval),
    .chan_map     (chan_map),
    .chan_ack     (chan_ack),
    .pr_done      (pr_done),
    .chan_req     (chan_req),
    .channel      (channel),
    .pr_run       (pr_run),
    .busy         (busy),
    .event_cnt    (event_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset(input string p);
    check({p, "_chan_req"}, chan_req, 0);
    check({p, "_channel"}, channel, 37);
    check({p, "_pr_run"}, pr_run, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_event_cnt"}, event_cnt, 0);
    check({p, "_timeout_err"}, timeout_err, 0);
  endtask

  // One channel: request held max(ack_d,1) cycles, then packet for done_d
  // cycles (0 = never) capped by the timeout, with one timeout pulse if capped.
  task automatic do_channel(input logic [5:0] exp_ch, input int ack_d, input int done_d,
                            input int drop_at, output int req_t, output int end_t);
    int n, m, terr, stray;
    bit timed_out;
    chan_ack = (ack_d == 0);
    n = 0;
    while (!chan_req && n < 2500) begin tick(); n++; end
    check("req_seen", chan_req, 1);
    req_t = cyc;
    check("req_channel", channel, exp_ch);
    check("busy_in_event", busy, 1);
    n = 0; stray = 0;
    while (chan_req && n < 200) begin
      n++;
      if (channel !== exp_ch) stray++;
      if (n >= ack_d) chan_ack = 1'b1;
      tick();
    end
    chan_ack = 1'b0;
    check("req_len", n, (ack_d > 1) ? ack_d : 1);
    check("pr_run_after_ack", pr_run, 1);
    m = 0; terr = 0;
    while (pr_run && m < 200) begin
      m++;
      if (channel !== exp_ch) stray++;
      if (timeout_err) terr++;
      pr_done = (done_d != 0 && m == done_d);
      if (drop_at != 0 && m == drop_at) enable = 1'b0;
      tick();
    end
    pr_done = 1'b0;
    end_t = cyc;
    if (timeout_err) terr++;
    timed_out = (done_d == 0 || done_d > TXTO);
    check("pr_len", m, timed_out ? TXTO : done_d);
    check("timeout_pulse", terr, timed_out);
    check("chan_stable", stray, 0);
    tick();
    check("timeout_one_cycle", timeout_err, 0);
  endtask

  task automatic wait_evcnt(input int exp);
    int n;
    n = 0;
    while (event_cnt !== 16'(exp) && n < 400) begin tick(); n++; end
    check("event_cnt", event_cnt, exp);
  endtask

  // Full event: visit set bits of map in ascending channel order, IFS gaps,
  // then one count; next_map is applied mid-event and must not disturb it.
  task automatic run_event(input logic [2:0] map, input logic [2:0] next_map,
                           input int ad[3], input int dd[3], output int first_req);
    int chs[$];
    int req_t, end_t, prev_end;
    for (int b = 0; b < 3; b++) if (map[b]) chs.push_back(37 + b);
    first_req = -1;
    prev_end = 0;
    foreach (chs[i]) begin
      do_channel(6'(chs[i]), ad[i], dd[i], 0, req_t, end_t);
      if (i == 0) begin
        first_req = req_t;
        chan_map = next_map;
      end else begin
        check("ifs_gap", req_t - prev_end, IFS);
      end
      prev_end = end_t;
    end
    if (chs.size() != 0) ev_model++;
    wait_evcnt(ev_model);
  endtask

  initial begin
    int t1, t2, t3, e37, r38, e38, n, stray;
    int ad[3], dd[3];
    logic [2:0] m, nm;

    repeat (3) tick();
    check_reset("reset");
    ready = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // All three channels, ack tied high, fixed packet length.
    adv_interval = 24'(IVL);
    chan_map = 3'b111;
    enable = 1'b1;
    ad = '{0, 0, 0};
    dd = '{40, 40, 40};
    run_event(3'b111, 3'b101, ad, dd, t1);

    // ch37: delayed ack and timeout; ch39: pr_done on the timeout cycle.
    ad = '{20, 0, 0};
    dd = '{0, 50, 0};
    run_event(3'b101, 3'b000, ad, dd, t2);
    check("interval", t2 - t1, IVL);

    // Empty map event: no request, no count, still busy waiting out the interval.
    n = 0; stray = 0;
    while (n < 2500) begin
      if (chan_req) stray++;
      tick(); n++;
    end
    check("empty_map_no_req", stray, 0);
    check("empty_map_no_count", event_cnt, ev_model);
    check("empty_map_busy", busy, 1);
    nm = 3'($urandom_range(1, 7));
    chan_map = nm;

    for (int e = 0; e < 4; e++) begin
      m = nm;
      nm = (e == 3) ? 3'b111 : 3'($urandom_range(1, 7));
      for (int k = 0; k < 3; k++) begin
        ad[k] = $urandom_range(0, 25);
        dd[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
      end
      run_event(m, nm, ad, dd, t3);
      check("interval_rand", t3 - t2, (e == 0) ? 2 * IVL : IVL);
      t2 = t3;
    end

    // enable dropped during ch38 packet: packet completes, gap, then idle.
    do_channel(6'd37, 3, 30, 0, t3, e37);
    check("interval_drop", t3 - t2, IVL);
    do_channel(6'd38, 0, 40, 5, r38, e38);
    check("ifs_gap_drop", r38 - e37, IFS);
    n = 0; stray = 0;
    while (busy && n < 400) begin
      if (chan_req) stray++;
      tick(); n++;
    end
    check("drop_idle", busy, 0);
    check("drop_no_req", stray, 0);
    check("drop_pr_run", pr_run, 0);
    check("drop_no_count", event_cnt, ev_model);

    // Reset while waiting for synthesizer lock on ch39.
    chan_map = 3'b100;
    adv_interval = 24'd300;
    enable = 1'b1;
    n = 0;
    while (!chan_req && n < 50) begin tick(); n++; end
    check("rst_tune_req", chan_req, 1);
    repeat (3) tick();
    ready = 1'b0;
    tick();
    check_reset("rst_tune");
    ev_model = 0;

    // Reset in the middle of a packet on ch38.
    chan_map = 3'b010;
    ready = 1'b1;
    n = 0;
    while (!chan_req && n < 50) begin tick(); n++; end
    chan_ack = 1'b1;
    n = 0;
    while (!pr_run && n < 50) begin tick(); n++; end
    repeat (4) tick();
    check("rst_tx_pr_run", pr_run, 1);
    check("rst_tx_channel", channel, 38);
    ready = 1'b0;
    tick();
    check_reset("rst_tx");
    chan_ack = 1'b0;
    enable = 1'b0;
    ready = 1'b1;
    repeat (5) tick();
    check("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
